stage3_execute: RTL and testbench

//  Execute stage of the 5-stage SCU pipeline; consumes the ID/EX bundle produced by decode (stage2).

---
 rtl/stage3_execute.sv | 168 ++++++++++++++++
 tb/tb_stage3_execute.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage3_execute.sv
// Execute stage of the SCU pipeline: ALU, Z/N flags, branch/jump resolution and the
// registered EX/MEM bundle, plus squashing of wrong-path instructions after a redirect.
module stage3_execute #(
  parameter int DW       = 32,
  parameter int RW       = 6,
  parameter int SQUASH_N = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_imm,
  input  logic [RW-1:0] in_rd,
  input  logic [DW-1:0] in_rd1,
  input  logic [DW-1:0] in_rd2,
  input  logic [DW-1:0] in_PC,
  input  logic          in_brz,
  input  logic          in_brn,
  input  logic          in_j,
  input  logic          in_regw,
  input  logic          in_wai,
  input  logic          in_memw,
  input  logic          in_memr,
  input  logic          in_alusrc,
  input  logic [2:0]    in_aluop,
  output logic          out_valid,
  output logic [DW-1:0] out_alu,
  output logic [DW-1:0] out_wdata,
  output logic [RW-1:0] out_rd,
  output logic          out_regw,
  output logic          out_wai,
  output logic          out_memw,
  output logic          out_memr,
  output logic          out_take,
  output logic [DW-1:0] out_target,
  output logic          out_z,
  output logic          out_n
);

  localparam int CW = (SQUASH_N < 1) ? 1 : $clog2(SQUASH_N + 1);

  // Slot protocol: there is no back-pressure. in_valid marks a real instruction in the
  // ID/EX slot for exactly the cycle it is presented; out_valid marks the EX/MEM slot the
  // same way one cycle later. Controls are zero whenever the slot is not valid.

  logic [DW-1:0] op_b;
  logic [DW-1:0] alu_res;
  logic          live;
  logic          take;
  logic          flag_upd;

  logic          valid_d,  valid_q;
  logic [DW-1:0] alu_d,    alu_q;
  logic [DW-1:0] wdata_d,  wdata_q;
  logic [RW-1:0] rd_d,     rd_q;
  logic          regw_d,   regw_q;
  logic          wai_d,    wai_q;
  logic          memw_d,   memw_q;
  logic          memr_d,   memr_q;
  logic          take_d,   take_q;
  logic [DW-1:0] target_d, target_q;
  logic          z_d,      z_q;
  logic          n_d,      n_q;
  logic [CW-1:0] sq_cnt_d, sq_cnt_q;

  // The PC is carried in the bundle for linking stages but the ALU never selects it.
  logic unused_pc;
  assign unused_pc = ^in_PC;

  assign op_b = in_alusrc ? in_imm : in_rd2;

  always_comb begin
    alu_res = in_rd1 + op_b;
    case (in_aluop)
      3'b000:  alu_res = in_rd1 + op_b;
      3'b001:  alu_res = in_rd1 - op_b;
      3'b010:  alu_res = '0 - in_rd1;
      3'b011:  alu_res = in_rd1;
      3'b100:  alu_res = op_b;
      3'b101:  alu_res = in_rd1 + DW'(1);
      default: alu_res = in_rd1 + op_b;
    endcase
  end

  // Branches test the flags as they stood before this instruction's own update.
  assign live     = in_valid && (sq_cnt_q == '0);
  assign take     = live && (in_j || (in_brz && z_q) || (in_brn && n_q));
  assign flag_upd = live && in_regw && !in_memr;

  always_comb begin
    valid_d  = live;
    regw_d   = live && in_regw;
    wai_d    = live && in_wai;
    memw_d   = live && in_memw;
    memr_d   = live && in_memr;
    take_d   = take;
    target_d = take ? in_rd1 : '0;
    alu_d    = alu_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    z_d      = z_q;
    n_d      = n_q;
    sq_cnt_d = sq_cnt_q;

    if (live) begin
      alu_d   = alu_res;
      wdata_d = in_rd2;
      rd_d    = in_rd;
    end

    if (flag_upd) begin
      z_d = (alu_res == '0);
      n_d = alu_res[DW-1];
    end

    // Only real instructions consume squash slots; pipeline bubbles pass through.
    if (take) begin
      sq_cnt_d = CW'(SQUASH_N);
    end else if (in_valid && (sq_cnt_q != '0)) begin
      sq_cnt_d = sq_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      alu_q    <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      regw_q   <= 1'b0;
      wai_q    <= 1'b0;
      memw_q   <= 1'b0;
      memr_q   <= 1'b0;
      take_q   <= 1'b0;
      target_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      sq_cnt_q <= '0;
    end else begin
      valid_q  <= valid_d;
      alu_q    <= alu_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      regw_q   <= regw_d;
      wai_q    <= wai_d;
      memw_q   <= memw_d;
      memr_q   <= memr_d;
      take_q   <= take_d;
      target_q <= target_d;
      z_q      <= z_d;
      n_q      <= n_d;
      sq_cnt_q <= sq_cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_alu    = alu_q;
  assign out_wdata  = wdata_q;
  assign out_rd     = rd_q;
  assign out_regw   = regw_q;
  assign out_wai    = wai_q;
  assign out_memw   = memw_q;
  assign out_memr   = memr_q;
  assign out_take   = take_q;
  assign out_target = target_q;
  assign out_z      = z_q;
  assign out_n      = n_q;

endmodule

// File: tb/tb_stage3_execute.sv
// Bench for stage3_execute: directed vector table, reset-in-squash sequence and a
// randomized ALU run, all checked through one expected-result queue.
module tb_stage3_execute;

  localparam int DW = 32;
  localparam int RW = 6;

  localparam logic [8:0] C_V   = 9'h100;
  localparam logic [8:0] C_BRZ = 9'h080;
  localparam logic [8:0] C_BRN = 9'h040;
  localparam logic [8:0] C_J   = 9'h020;
  localparam logic [8:0] C_RW  = 9'h010;
  localparam logic [8:0] C_WAI = 9'h008;
  localparam logic [8:0] C_MW  = 9'h004;
  localparam logic [8:0] C_MR  = 9'h002;
  localparam logic [8:0] C_SRC = 9'h001;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_brz, in_brn, in_j, in_regw, in_wai, in_memw, in_memr, in_alusrc;
  logic [DW-1:0] in_imm, in_rd1, in_rd2, in_PC;
  logic [RW-1:0] in_rd;
  logic [2:0]    in_aluop;
  logic          out_valid, out_regw, out_wai, out_memw, out_memr, out_take, out_z, out_n;
  logic [DW-1:0] out_alu, out_wdata, out_target;
  logic [RW-1:0] out_rd;

  // ctl = {regw, wai, memw, memr}; chk=0 means data outputs are don't-care (bubble)
  typedef struct packed {
    logic          chk;
    logic          valid;
    logic [31:0]   alu;
    logic [31:0]   wdata;
    logic [5:0]    rd;
    logic [3:0]    ctl;
    logic          take;
    logic [31:0]   target;
    logic          z;
    logic          n;
  } exp_t;

  localparam int EW = $bits(exp_t);

  typedef struct {
    logic [8:0]  ctl;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [5:0]  rd;
    exp_t        e;
  } vec_t;

  logic [EW-1:0] exp_q[$];
  vec_t          tbl[$];
  int            n_checks = 0;
  int            n_errors = 0;

  stage3_execute #(.DW(DW), .RW(RW), .SQUASH_N(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_imm(in_imm), .in_rd(in_rd), .in_rd1(in_rd1), .in_rd2(in_rd2),
    .in_PC(in_PC), .in_brz(in_brz), .in_brn(in_brn), .in_j(in_j), .in_regw(in_regw),
    .in_wai(in_wai), .in_memw(in_memw), .in_memr(in_memr), .in_alusrc(in_alusrc),
    .in_aluop(in_aluop),
    .out_valid(out_valid), .out_alu(out_alu), .out_wdata(out_wdata), .out_rd(out_rd),
    .out_regw(out_regw), .out_wai(out_wai), .out_memw(out_memw), .out_memr(out_memr),
    .out_take(out_take), .out_target(out_target), .out_z(out_z), .out_n(out_n)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic exp_t ex(input logic chk, input logic valid, input logic [31:0] alu,
                              input logic [31:0] wdata, input logic [5:0] rd,
                              input logic [3:0] ctl, input logic take,
                              input logic [31:0] tgt, input logic z, input logic n);
    exp_t e;
    e.chk = chk; e.valid = valid; e.alu = alu; e.wdata = wdata; e.rd = rd;
    e.ctl = ctl; e.take = take; e.target = tgt; e.z = z; e.n = n;
    return e;
  endfunction

  function automatic vec_t mk(input logic [8:0] ctl, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic [5:0] rd, input exp_t e);
    vec_t v;
    v.ctl = ctl; v.op = op; v.a = a; v.b = b; v.imm = imm; v.rd = rd; v.e = e;
    return v;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return 32'd0 - a;
      3'd3: return a;
      3'd4: return b;
      3'd5: return a + 32'd1;
      default: return a + b;
    endcase
  endfunction

  // driver tasks
  task automatic drive(input vec_t v);
    {in_valid, in_brz, in_brn, in_j, in_regw, in_wai, in_memw, in_memr, in_alusrc} = v.ctl;
    in_aluop = v.op;
    in_rd1   = v.a;
    in_rd2   = v.b;
    in_imm   = v.imm;
    in_rd    = v.rd;
    in_PC    = $urandom;
  endtask

  // scoreboard
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: expected queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      cmp({tag, " valid"},  32'(out_valid), 32'(e.valid));
      cmp({tag, " regw"},   32'(out_regw),  32'(e.ctl[3]));
      cmp({tag, " wai"},    32'(out_wai),   32'(e.ctl[2]));
      cmp({tag, " memw"},   32'(out_memw),  32'(e.ctl[1]));
      cmp({tag, " memr"},   32'(out_memr),  32'(e.ctl[0]));
      cmp({tag, " take"},   32'(out_take),  32'(e.take));
      cmp({tag, " target"}, out_target,     e.target);
      cmp({tag, " z"},      32'(out_z),     32'(e.z));
      cmp({tag, " n"},      32'(out_n),     32'(e.n));
      if (e.chk) begin
        cmp({tag, " alu"},   out_alu,        e.alu);
        cmp({tag, " wdata"}, out_wdata,      e.wdata);
        cmp({tag, " rd"},    32'(out_rd),    32'(e.rd));
      end
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    drive(v);
    exp_q.push_back(v.e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  exp_t zero_e;
  vec_t v;

  initial begin
    logic        mz, mn, rv, rregw, rmr, rmw, rwai, rsrc;
    logic [2:0]  rop;
    logic [31:0] ra, rb, rimm, rres;
    logic [5:0]  rrd;

    zero_e = ex(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);

    // directed table: ADD, SUB->Z, BRZ, squash window with a bubble, NEG/BRZ/BRN,
    // branches inside the squash window, load/store, remaining aluops, J with link
    tbl.push_back(mk(C_V|C_RW,  0, 5, 7, 0, 3,   ex(1,1,12,7,3,4'b1000,0,0,0,0)));
    tbl.push_back(mk(C_V|C_RW,  1, 9, 9, 0, 4,   ex(1,1,0,9,4,4'b1000,0,0,1,0)));
    tbl.push_back(mk(C_V|C_BRZ, 0, 'h40, 0, 0, 0, ex(1,1,'h40,0,0,4'b0000,1,'h40,1,0)));
    tbl.push_back(mk(C_V|C_RW,  0, 1, 1, 0, 5,   ex(0,0,0,0,0,4'b0000,0,0,1,0)));
    tbl.push_back(mk(9'h000,    0, 0, 0, 0, 0,   ex(0,0,0,0,0,4'b0000,0,0,1,0)));
    tbl.push_back(mk(C_V|C_RW,  0, 2, 3, 0, 6,   ex(0,0,0,0,0,4'b0000,0,0,1,0)));
    tbl.push_back(mk(C_V|C_RW,  0, 2, 3, 0, 6,   ex(1,1,5,3,6,4'b1000,0,0,0,0)));
    tbl.push_back(mk(C_V|C_RW,  2, 1, 0, 0, 7,   ex(1,1,32'hFFFF_FFFF,0,7,4'b1000,0,0,0,1)));
    tbl.push_back(mk(C_V|C_BRZ, 0, 'h20, 0, 0, 0, ex(1,1,'h20,0,0,4'b0000,0,0,0,1)));
    tbl.push_back(mk(C_V|C_BRN, 0, 'h10, 0, 0, 0, ex(1,1,'h10,0,0,4'b0000,1,'h10,0,1)));
    tbl.push_back(mk(C_V|C_BRN, 0, 'h30, 0, 0, 0, ex(0,0,0,0,0,4'b0000,0,0,0,1)));
    tbl.push_back(mk(C_V|C_J,   0, 'h50, 0, 0, 0, ex(0,0,0,0,0,4'b0000,0,0,0,1)));
    tbl.push_back(mk(C_V|C_RW|C_MR|C_SRC, 0, 'h100, 'h55, 4, 8,
                     ex(1,1,'h104,'h55,8,4'b1001,0,0,0,1)));
    tbl.push_back(mk(C_V|C_MW|C_SRC, 0, 'h200, 'hAB, 8, 0,
                     ex(1,1,'h208,'hAB,0,4'b0010,0,0,0,1)));
    tbl.push_back(mk(C_V|C_RW,  3, 32'h8000_0000, 5, 0, 9,
                     ex(1,1,32'h8000_0000,5,9,4'b1000,0,0,0,1)));
    tbl.push_back(mk(C_V|C_RW,  4, 3, 0, 0, 10,  ex(1,1,0,0,10,4'b1000,0,0,1,0)));
    tbl.push_back(mk(C_V|C_RW,  5, 32'hFFFF_FFFF, 7, 0, 11,
                     ex(1,1,0,7,11,4'b1000,0,0,1,0)));
    tbl.push_back(mk(C_V|C_RW,  6, 2, 3, 0, 12,  ex(1,1,5,3,12,4'b1000,0,0,0,0)));
    tbl.push_back(mk(C_V|C_RW|C_SRC, 7, 'h10, 1, 'h20, 13,
                     ex(1,1,'h30,1,13,4'b1000,0,0,0,0)));
    tbl.push_back(mk(C_V|C_BRN, 0, 'h60, 0, 0, 0, ex(1,1,'h60,0,0,4'b0000,0,0,0,0)));
    tbl.push_back(mk(C_V|C_J|C_RW|C_WAI, 3, 'h300, 0, 0, 31,
                     ex(1,1,'h300,0,31,4'b1100,1,'h300,0,0)));
    tbl.push_back(mk(C_V|C_RW,  0, 0, 0, 0, 1,   ex(0,0,0,0,0,4'b0000,0,0,0,0)));
    tbl.push_back(mk(C_V|C_RW,  0, 0, 0, 0, 1,   ex(0,0,0,0,0,4'b0000,0,0,0,0)));
    tbl.push_back(mk(C_V|C_RW,  0, 0, 0, 0, 1,   ex(1,1,0,0,1,4'b1000,0,0,1,0)));

    rst_n = 1'b0;
    drive(mk(9'h000, 0, 0, 0, 0, 0, zero_e));
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(zero_e);
    check_out("reset");
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // taken BRZ, then async reset while the squash window is open
    step(mk(C_V|C_BRZ, 0, 'h44, 0, 0, 0, ex(1,1,'h44,0,0,4'b0000,1,'h44,1,0)), "rst_brz");
    drive(mk(C_V|C_RW, 0, 1, 1, 0, 2, zero_e));
    rst_n = 1'b0;
    #1;
    exp_q.push_back(zero_e);
    check_out("rst_async");
    @(posedge clk);
    #1;
    exp_q.push_back(zero_e);
    check_out("rst_hold");
    rst_n = 1'b1;
    step(mk(C_V|C_RW, 0, 1, 1, 0, 2, ex(1,1,2,1,2,4'b1000,0,0,0,0)), "post_rst");

    // randomized non-branch traffic against a reference ALU and flag model
    mz = 1'b0;
    mn = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rv    = ($urandom_range(0, 3) != 0);
      rop   = 3'($urandom_range(0, 7));
      rsrc  = 1'($urandom_range(0, 1));
      rregw = 1'($urandom_range(0, 1));
      rwai  = 1'($urandom_range(0, 1));
      rmr   = ($urandom_range(0, 3) == 0);
      rmw   = ($urandom_range(0, 3) == 0);
      ra    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rb    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rimm  = $urandom;
      rrd   = 6'($urandom_range(0, 63));
      rres  = alu_ref(rop, ra, rsrc ? rimm : rb);
      if (rv && rregw && !rmr) begin
        mz = (rres == 32'd0);
        mn = rres[31];
      end
      v = mk({rv, 3'b000, rregw, rwai, rmw, rmr, rsrc}, rop, ra, rb, rimm, rrd,
             ex(rv, rv, rres, rb, rrd, rv ? {rregw, rwai, rmw, rmr} : 4'b0000, 0, 0, mz, mn));
      step(v, $sformatf("rnd%0d", i));
    end

    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected entries left, 0 required", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
